tohost_monitor: RTL

TOHOST_MONITOR -- requirements
Module: tohost_monitor

---
 rtl/tohost_monitor_pkg.sv | 21 ++
 rtl/tohost_monitor_led_blinker.sv | 75 +++++++
 rtl/tohost_monitor.sv | 97 +++++++++
 3 files changed

// File: rtl/tohost_monitor_pkg.sv
// Shared definitions for the tohost monitor: the FSM state encoding, the
// value that signals a pass, the timeout fail code, and a helper that
// clamps a fail code to a pulse count the LED can show.
package tohost_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [31:0] PASS_VALUE   = 32'd1;
  localparam logic [30:0] TIMEOUT_CODE = 31'h7FFF_FFFF;

  // The LED can show at most 15 pulses; larger fail codes saturate.
  function automatic logic [3:0] clamp_pulses(input logic [30:0] code);
    return (code > 31'd15) ? 4'd15 : code[3:0];
  endfunction

endpackage

// File: rtl/tohost_monitor_led_blinker.sv
// led_blinker: produces the board status LED pattern for the monitor mode.
//   sysclk    : clock, rising edge
//   rst       : asynchronous active-low reset
//   mode      : current monitor state (state_e encoding)
//   pulse_cnt : number of pulses to show in FAIL (0..15)
//   led       : LED output
// RUN: toggle every BLINK_DIV cycles. PASS: on. FAIL: N pulses of
// BLINK_DIV on / BLINK_DIV off, then 4*BLINK_DIV off, repeated.
// TIMEOUT: toggle every BLINK_DIV/4 cycles.
module led_blinker
  import tohost_monitor_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic [3:0] pulse_cnt,
  output logic       led
);

  localparam int SLOW_DIV = (BLINK_DIV > 0) ? BLINK_DIV : 1;
  localparam int FAST_DIV = (BLINK_DIV / 4 > 0) ? BLINK_DIV / 4 : 1;
  localparam int CW       = $clog2(SLOW_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_cur, lim;
  logic [5:0]    slot_q, slot_cur, slot_last;
  logic          tgl_q, tgl_cur;
  logic [1:0]    mode_q;
  logic          change;

  // On a mode change the counters restart in the same cycle, so the new
  // pattern begins immediately rather than one cycle late.
  always_comb begin
    change    = (mode != mode_q);
    cnt_cur   = change ? '0 : cnt_q;
    slot_cur  = change ? '0 : slot_q;
    tgl_cur   = change ? 1'b0 : tgl_q;
    lim       = (mode == ST_TIMEOUT) ? CW'(FAST_DIV - 1) : CW'(SLOW_DIV - 1);
    // 2N pulse slots (on/off) plus 4 gap slots; index of the last one.
    slot_last = {1'b0, pulse_cnt, 1'b0} + 6'd3;
    led       = 1'b0;
    case (mode)
      ST_RUN:     led = tgl_cur;
      ST_PASS:    led = 1'b1;
      ST_FAIL:    led = (slot_cur < {1'b0, pulse_cnt, 1'b0}) && !slot_cur[0];
      ST_TIMEOUT: led = tgl_cur;
      default:    led = 1'b0;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      mode_q <= ST_RUN;
      cnt_q  <= '0;
      slot_q <= '0;
      tgl_q  <= 1'b0;
    end else begin
      mode_q <= mode;
      if (cnt_cur == lim) begin
        cnt_q  <= '0;
        tgl_q  <= ~tgl_cur;
        if (mode == ST_FAIL)
          slot_q <= (slot_cur == slot_last) ? 6'd0 : slot_cur + 6'd1;
        else
          slot_q <= '0;
      end else begin
        cnt_q  <= cnt_cur + CW'(1);
        tgl_q  <= tgl_cur;
        slot_q <= slot_cur;
      end
    end
  end

endmodule

// File: rtl/tohost_monitor.sv
// tohost_monitor: passive snooper of the CPU data-memory write bus. It
// watches for a full-word nonzero write to TOHOST_ADDR and latches the
// first test result (pass / fail code) or a timeout.
//   sysclk     : clock, rising edge
//   rst        : asynchronous active-low reset
//   dmem_we    : write strobe         dmem_addr : byte address
//   dmem_be    : byte enables         dmem_wdata: write data
//   done       : result available     pass      : test passed
//   fail_code  : failing test number (all ones on timeout)
//   cycles     : RUN cycles counted up to completion
//   led        : board status LED
module tohost_monitor
  import tohost_monitor_pkg::*;
#(
  parameter int TOHOST_ADDR    = 16384,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int BLINK_DIV      = 25000000
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  dmem_we,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [3:0]            dmem_be,
  input  logic [31:0]           dmem_wdata,
  output logic                  done,
  output logic                  pass,
  output logic [30:0]           fail_code,
  output logic [31:0]           cycles,
  output logic                  led
);

  state_e      state_q, state_d;
  logic        done_d, pass_d;
  logic [30:0] fail_code_d;
  logic [31:0] cycles_d;
  logic        hit, tmo;

  // Full-width address compare; partial or zero writes never count.
  assign hit = dmem_we && (dmem_addr == ADDR_WIDTH'(TOHOST_ADDR)) &&
               (dmem_be == 4'hF) && (dmem_wdata != 32'd0);
  assign tmo = (cycles == 32'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d     = state_q;
    done_d      = done;
    pass_d      = pass;
    fail_code_d = fail_code;
    cycles_d    = cycles;
    if (state_q == ST_RUN) begin
      // A hit takes priority over a coincident timeout. The leaving edge
      // does not increment, so cycles freezes at the value of the final
      // RUN cycle.
      if (hit) begin
        done_d = 1'b1;
        if (dmem_wdata == PASS_VALUE) begin
          state_d = ST_PASS;
          pass_d  = 1'b1;
        end else begin
          state_d     = ST_FAIL;
          fail_code_d = dmem_wdata[0] ? dmem_wdata[31:1] : 31'd0;
        end
      end else if (tmo) begin
        state_d     = ST_TIMEOUT;
        done_d      = 1'b1;
        fail_code_d = TIMEOUT_CODE;
      end else begin
        cycles_d = cycles + 32'd1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= '0;
      cycles    <= '0;
    end else begin
      state_q   <= state_d;
      done      <= done_d;
      pass      <= pass_d;
      fail_code <= fail_code_d;
      cycles    <= cycles_d;
    end
  end

  led_blinker #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .sysclk    (sysclk),
    .rst       (rst),
    .mode      (state_q),
    .pulse_cnt (clamp_pulses(fail_code)),
    .led       (led)
  );

endmodule
